addarray_ctrl: RTL and testbench
================================

Name: addarray_ctrl

Overview:
- Sequencer that drives the four-lane add array and consumes its results, one lane per 16-bit quantity. It owns four accumulator lanes (the A operands) and four step lanes (the B operands).
- On each step it presents accumulator, step and mode to the array, waits for the sums, and writes them back to the accumulators. It counts steps down to a programmed pixel count.
- Sits between the blitter's register interface and the add array. It performs Gouraud intensity and Z iteration along a span.

Parameters:
- ADD_LAT, 1, number of enabled clk_0 cycles from operand presentation to a valid addq; legal range 1..3.
- CNT_W, 16, width of the step counter.

Ports:
- sys_clk  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  synchronous active-low reset.
- clk_0  in  1  phase enable; state advances only on edges where clk_0=1 (reset excepted).
- ld_acc  in  1  load the four accumulators from ld_data.
- ld_step  in  1  load the four step registers from ld_data.
- ld_data  in  64  lane n occupies bits [16n+15:16n].
- mode_in  in  3  add mode, captured on start.
- count_in  in  CNT_W  number of steps, captured on start.
- start  in  1  begin a span.
- busy  out  1  span in progress.
- done  out  1  one-cycle pulse at span end.
- acc_vld  out  1  one-cycle pulse when the accumulators are updated.
- acc_q  out  64  current accumulator lanes.
- adda_0..adda_3  out  16 each  A operands to the array.
- addb_0..addb_3  out  16 each  B operands to the array.
- daddmode  out  3  mode to the array.
- addq_0..addq_3  in  16 each  sums returned by the array.

Behaviour:
- Reset (reset_n=0 at a sys_clk edge, regardless of clk_0) clears the following to 0:
  - accumulators, steps, adda/addb, daddmode, counter, wait counter;
  - busy, done, acc_vld.
  - State returns to IDLE. Reset mid-span aborts the span with no done pulse.
- All non-reset updates require clk_0=1. With clk_0=0, every register holds and the done/acc_vld pulses are held.
- State machine: IDLE, ISSUE, WAIT, CAPT, FIN.
- IDLE:
  - ld_acc loads the accumulators; ld_step loads the steps.
  - If ld_acc and ld_step are both asserted, both load from the same ld_data.
  - start captures mode_in and count_in.
    - count_in=0: go to FIN (no issue).
    - Otherwise go to ISSUE and set busy=1.
  - start together with ld_*: the load takes effect first, and the span uses the loaded values.
- ISSUE: register adda_n=acc_n, addb_n=step_n, daddmode=mode; set wait counter=ADD_LAT; go to WAIT.
- WAIT: decrement the wait counter each enabled cycle; go to CAPT when it reaches 0.
  - Operands are held stable for the whole of WAIT.
- CAPT:
  - acc_n<=addq_n for all four lanes; acc_vld=1 for one enabled cycle; counter-=1.
  - Counter now 0: go to FIN. Otherwise go to ISSUE.
- FIN: done=1 for one enabled cycle, busy=0, return to IDLE.
- ld_acc, ld_step and start are ignored while busy=1.
- Throughput: ADD_LAT+2 enabled cycles per step.
- Span latency from start: count*(ADD_LAT+2)+1 enabled cycles to done.
- Arithmetic, saturation and wrap are entirely the array's concern. This block copies addq verbatim.
- Counter is unsigned CNT_W bits. Max span is 2^CNT_W-1 steps, with no wrap.

Decomposition:
- Shared package holds:
  - the state enum (IDLE/ISSUE/WAIT/CAPT/FIN);
  - the lane count (4) and lane width (16);
  - the daddmode encoding constants used by the array.
- One natural sub-module: addarray_lane_reg. It holds one lane's accumulator and step registers with load and capture muxing, and is instantiated four times.

Test Plan:
- Reset: drive reset_n=0 for one edge with clk_0=0 -> all outputs 0 and busy=0 on the next cycle.
- Basic span:
  - ld_acc with lanes {0x0010,0x0020,0x0030,0x0040}, ld_step with all lanes 0x0001, start count=3, mode=0.
  - Bench model: addq=adda+addb, ADD_LAT=1.
  - Required: three acc_vld pulses 3 cycles apart; final acc_q lanes {0x0013,0x0023,0x0033,0x0043}; done 10 cycles after start.
- Zero count: start with count_in=0 -> done pulses on the next enabled cycle; no acc_vld; accumulators unchanged.
- Gating: toggle clk_0 every other cycle during the basic span -> same final values, and done appears at twice the enabled-cycle latency.
- Busy protection: assert ld_acc=0xFFFF lanes and start during WAIT -> both ignored; results identical to the basic span.
- Reset mid-span: reset_n=0 during the second WAIT -> busy=0, acc_q=0, no done pulse; a new start afterwards runs normally.

Source files
------------

// File: rtl/addarray_ctrl_pkg.sv
// Shared types and constants for the add-array sequencer.
package addarray_ctrl_pkg;

    localparam int unsigned LANES  = 4;
    localparam int unsigned LANE_W = 16;
    localparam int unsigned DATA_W = LANES * LANE_W;
    localparam int unsigned MODE_W = 3;
    localparam int unsigned WAIT_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CAPT  = 3'd3,
        ST_FIN   = 3'd4
    } state_e;

    // daddmode encodings understood by the add array
    localparam logic [MODE_W-1:0] DADD_WRAP16  = 3'd0;  // plain 16-bit wrap add
    localparam logic [MODE_W-1:0] DADD_SAT8    = 3'd1;  // Gouraud intensity, clamp 8.8
    localparam logic [MODE_W-1:0] DADD_Z32_LO  = 3'd2;  // low half of 32-bit Z
    localparam logic [MODE_W-1:0] DADD_Z32_HI  = 3'd3;  // high half, carry-in from lo
    localparam logic [MODE_W-1:0] DADD_SAT16   = 3'd4;  // unsigned 16-bit clamp

    // Extract lane n from a packed four-lane word
    function automatic logic [LANE_W-1:0] lane_of(input logic [DATA_W-1:0] d,
                                                  input int unsigned n);
        return d[LANE_W*n +: LANE_W];
    endfunction

endpackage

// File: rtl/addarray_lane_reg.sv
// One lane's accumulator and step registers with load/capture muxing.
module addarray_lane_reg
    import addarray_ctrl_pkg::*;
(
    input  logic              sys_clk,
    input  logic              reset_n,
    input  logic              ld_acc,
    input  logic              ld_step,
    input  logic              cap,
    input  logic [LANE_W-1:0] ld_lane,
    input  logic [LANE_W-1:0] addq,
    output logic [LANE_W-1:0] acc,
    output logic [LANE_W-1:0] step
);

    // Capture and load are never both asserted; capture wins if they were
    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            acc  <= '0;
            step <= '0;
        end else begin
            if (cap) begin
                acc <= addq;
            end else if (ld_acc) begin
                acc <= ld_lane;
            end
            if (ld_step) begin
                step <= ld_lane;
            end
        end
    end

endmodule

// File: rtl/addarray_ctrl.sv
// Sequencer driving the four-lane add array along a span.
module addarray_ctrl
    import addarray_ctrl_pkg::*;
#(
    parameter int unsigned ADD_LAT = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              sys_clk,
    input  logic              reset_n,
    input  logic              clk_0,
    input  logic              ld_acc,
    input  logic              ld_step,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [MODE_W-1:0] mode_in,
    input  logic [CNT_W-1:0]  count_in,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              acc_vld,
    output logic [DATA_W-1:0] acc_q,
    output logic [LANE_W-1:0] adda_0,
    output logic [LANE_W-1:0] adda_1,
    output logic [LANE_W-1:0] adda_2,
    output logic [LANE_W-1:0] adda_3,
    output logic [LANE_W-1:0] addb_0,
    output logic [LANE_W-1:0] addb_1,
    output logic [LANE_W-1:0] addb_2,
    output logic [LANE_W-1:0] addb_3,
    output logic [MODE_W-1:0] daddmode,
    input  logic [LANE_W-1:0] addq_0,
    input  logic [LANE_W-1:0] addq_1,
    input  logic [LANE_W-1:0] addq_2,
    input  logic [LANE_W-1:0] addq_3
);

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [WAIT_W-1:0]   wait_q;
    logic [MODE_W-1:0]   mode_q;
    logic [MODE_W-1:0]   daddmode_q;
    logic                busy_q;
    logic                done_q;
    logic                acc_vld_q;
    logic [LANE_W-1:0]   adda_q [LANES];
    logic [LANE_W-1:0]   addb_q [LANES];
    logic [LANE_W-1:0]   acc_a  [LANES];
    logic [LANE_W-1:0]   step_a [LANES];
    logic [LANE_W-1:0]   addq_a [LANES];

    logic ld_acc_en_c;
    logic ld_step_en_c;
    logic cap_en_c;

    // Loads only land while idle; capture only in CAPT; both need the phase enable
    assign ld_acc_en_c  = clk_0 && (state_q == ST_IDLE) && ld_acc;
    assign ld_step_en_c = clk_0 && (state_q == ST_IDLE) && ld_step;
    assign cap_en_c     = clk_0 && (state_q == ST_CAPT);

    assign addq_a[0] = addq_0;
    assign addq_a[1] = addq_1;
    assign addq_a[2] = addq_2;
    assign addq_a[3] = addq_3;

    addarray_lane_reg u_lane0 (
        .sys_clk (sys_clk), .reset_n (reset_n),
        .ld_acc  (ld_acc_en_c), .ld_step (ld_step_en_c), .cap (cap_en_c),
        .ld_lane (lane_of(ld_data, 0)), .addq (addq_a[0]),
        .acc     (acc_a[0]), .step (step_a[0])
    );
    addarray_lane_reg u_lane1 (
        .sys_clk (sys_clk), .reset_n (reset_n),
        .ld_acc  (ld_acc_en_c), .ld_step (ld_step_en_c), .cap (cap_en_c),
        .ld_lane (lane_of(ld_data, 1)), .addq (addq_a[1]),
        .acc     (acc_a[1]), .step (step_a[1])
    );
    addarray_lane_reg u_lane2 (
        .sys_clk (sys_clk), .reset_n (reset_n),
        .ld_acc  (ld_acc_en_c), .ld_step (ld_step_en_c), .cap (cap_en_c),
        .ld_lane (lane_of(ld_data, 2)), .addq (addq_a[2]),
        .acc     (acc_a[2]), .step (step_a[2])
    );
    addarray_lane_reg u_lane3 (
        .sys_clk (sys_clk), .reset_n (reset_n),
        .ld_acc  (ld_acc_en_c), .ld_step (ld_step_en_c), .cap (cap_en_c),
        .ld_lane (lane_of(ld_data, 3)), .addq (addq_a[3]),
        .acc     (acc_a[3]), .step (step_a[3])
    );

    // Span sequencer; pulses clear only on enabled edges so they hold across clk_0=0
    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            wait_q     <= '0;
            mode_q     <= '0;
            daddmode_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            acc_vld_q  <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                adda_q[i] <= '0;
                addb_q[i] <= '0;
            end
        end else if (clk_0) begin
            done_q    <= 1'b0;
            acc_vld_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mode_q <= mode_in;
                        cnt_q  <= count_in;
                        if (count_in == '0) begin
                            state_q <= ST_FIN;
                        end else begin
                            state_q <= ST_ISSUE;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    for (int i = 0; i < LANES; i++) begin
                        adda_q[i] <= acc_a[i];
                        addb_q[i] <= step_a[i];
                    end
                    daddmode_q <= mode_q;
                    wait_q     <= WAIT_W'(ADD_LAT);
                    state_q    <= ST_WAIT;
                end
                ST_WAIT: begin
                    wait_q <= wait_q - WAIT_W'(1);
                    if (wait_q == WAIT_W'(1)) begin
                        state_q <= ST_CAPT;
                    end
                end
                ST_CAPT: begin
                    acc_vld_q <= 1'b1;
                    cnt_q     <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= ST_FIN;
                    end else begin
                        state_q <= ST_ISSUE;
                    end
                end
                ST_FIN: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign acc_vld  = acc_vld_q;
    assign acc_q    = {acc_a[3], acc_a[2], acc_a[1], acc_a[0]};
    assign adda_0   = adda_q[0];
    assign adda_1   = adda_q[1];
    assign adda_2   = adda_q[2];
    assign adda_3   = adda_q[3];
    assign addb_0   = addb_q[0];
    assign addb_1   = addb_q[1];
    assign addb_2   = addb_q[2];
    assign addb_3   = addb_q[3];
    assign daddmode = daddmode_q;

endmodule

// File: tb/tb_addarray_ctrl.sv
// Directed bench for addarray_ctrl with a wrap-add array model (ADD_LAT=1).
module tb_addarray_ctrl;
    import addarray_ctrl_pkg::*;

    logic        sys_clk = 1'b0;
    logic        reset_n;
    logic        clk_0;
    logic        ld_acc;
    logic        ld_step;
    logic [63:0] ld_data;
    logic [2:0]  mode_in;
    logic [15:0] count_in;
    logic        start;
    logic        busy, done, acc_vld;
    logic [63:0] acc_q;
    logic [15:0] adda_0, adda_1, adda_2, adda_3;
    logic [15:0] addb_0, addb_1, addb_2, addb_3;
    logic [2:0]  daddmode;
    logic [15:0] addq_0, addq_1, addq_2, addq_3;

    int n_assert = 0;
    int n_fail   = 0;
    int done_cyc;
    int nvld;
    int vld_at [3];

    always #5 sys_clk = ~sys_clk;

    // Array model: plain 16-bit add of the presented operands
    assign addq_0 = adda_0 + addb_0;
    assign addq_1 = adda_1 + addb_1;
    assign addq_2 = adda_2 + addb_2;
    assign addq_3 = adda_3 + addb_3;

    addarray_ctrl #(.ADD_LAT(1), .CNT_W(16)) dut (
        .sys_clk (sys_clk), .reset_n (reset_n), .clk_0 (clk_0),
        .ld_acc (ld_acc), .ld_step (ld_step), .ld_data (ld_data),
        .mode_in (mode_in), .count_in (count_in), .start (start),
        .busy (busy), .done (done), .acc_vld (acc_vld), .acc_q (acc_q),
        .adda_0 (adda_0), .adda_1 (adda_1), .adda_2 (adda_2), .adda_3 (adda_3),
        .addb_0 (addb_0), .addb_1 (addb_1), .addb_2 (addb_2), .addb_3 (addb_3),
        .daddmode (daddmode),
        .addq_0 (addq_0), .addq_1 (addq_1), .addq_2 (addq_2), .addq_3 (addq_3)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic load_basic();
        ld_data = {16'h0040, 16'h0030, 16'h0020, 16'h0010};
        ld_acc  = 1'b1;
        tick();
        ld_acc  = 1'b0;
        ld_data = {4{16'h0001}};
        ld_step = 1'b1;
        tick();
        ld_step = 1'b0;
        ld_data = '0;
    endtask

    // Start a span and count raw cycles to done; records acc_vld rising cycles
    task automatic run_span(input logic [2:0] mode, input logic [15:0] cnt,
                            input int max, input bit gate, input bit poke);
        logic prev;
        mode_in  = mode;
        count_in = cnt;
        clk_0    = 1'b1;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        done_cyc = -1;
        nvld     = 0;
        vld_at   = '{-1, -1, -1};
        prev     = 1'b0;
        for (int c = 1; c <= max; c++) begin
            if (gate) clk_0 = (c % 2 == 0);
            if (poke && c == 2) begin
                ld_acc   = 1'b1;
                ld_data  = {4{16'hFFFF}};
                count_in = 16'd7;
                start    = 1'b1;
            end
            if (poke && c == 3) begin
                ld_acc  = 1'b0;
                ld_data = '0;
                start   = 1'b0;
            end
            tick();
            if (acc_vld && !prev) begin
                if (nvld < 3) vld_at[nvld] = c;
                nvld++;
            end
            prev = acc_vld;
            if (done) begin
                done_cyc = c;
                break;
            end
        end
        clk_0 = 1'b1;
    endtask

    initial begin
        bit saw_done;
        reset_n  = 1'b0;
        clk_0    = 1'b0;
        ld_acc   = 1'b0;
        ld_step  = 1'b0;
        ld_data  = '0;
        mode_in  = '0;
        count_in = '0;
        start    = 1'b0;

        // Reset with phase enable low
        tick();
        reset_n = 1'b1;
        clk_0   = 1'b1;
        check("rst_busy",     64'(busy),     64'd0);
        check("rst_done",     64'(done),     64'd0);
        check("rst_acc_vld",  64'(acc_vld),  64'd0);
        check("rst_acc_q",    acc_q,         64'd0);
        check("rst_adda_0",   64'(adda_0),   64'd0);
        check("rst_addb_3",   64'(addb_3),   64'd0);
        check("rst_daddmode", 64'(daddmode), 64'd0);

        // Basic three-step span
        load_basic();
        run_span(DADD_WRAP16, 16'd3, 40, 1'b0, 1'b0);
        check("basic_done_cyc", 64'(done_cyc),  64'd10);
        check("basic_nvld",     64'(nvld),      64'd3);
        check("basic_vld0",     64'(vld_at[0]), 64'd3);
        check("basic_vld1",     64'(vld_at[1]), 64'd6);
        check("basic_vld2",     64'(vld_at[2]), 64'd9);
        check("basic_acc_q",    acc_q,          64'h0043_0033_0023_0013);
        check("basic_busy",     64'(busy),      64'd0);
        check("basic_adda_0",   64'(adda_0),    64'h0012);

        // Zero-count span
        run_span(3'd5, 16'd0, 10, 1'b0, 1'b0);
        check("zero_done_cyc", 64'(done_cyc), 64'd1);
        check("zero_nvld",     64'(nvld),     64'd0);
        check("zero_acc_q",    acc_q,         64'h0043_0033_0023_0013);
        check("zero_daddmode", 64'(daddmode), 64'd0);

        // Phase enable toggling every other cycle
        load_basic();
        run_span(DADD_WRAP16, 16'd3, 60, 1'b1, 1'b0);
        check("gate_done_cyc", 64'(done_cyc),  64'd20);
        check("gate_nvld",     64'(nvld),      64'd3);
        check("gate_vld0",     64'(vld_at[0]), 64'd6);
        check("gate_vld2",     64'(vld_at[2]), 64'd18);
        check("gate_acc_q",    acc_q,          64'h0043_0033_0023_0013);

        // Load and start during WAIT are ignored
        load_basic();
        run_span(DADD_WRAP16, 16'd3, 40, 1'b0, 1'b1);
        check("busy_done_cyc", 64'(done_cyc), 64'd10);
        check("busy_nvld",     64'(nvld),     64'd3);
        check("busy_acc_q",    acc_q,         64'h0043_0033_0023_0013);
        tick();
        tick();
        tick();
        check("busy_no_restart", 64'(busy), 64'd0);

        // Reset during the second WAIT
        load_basic();
        mode_in  = DADD_WRAP16;
        count_in = 16'd3;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("mid_in_span", 64'(busy), 64'd1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("mid_busy",  64'(busy),  64'd0);
        check("mid_acc_q", acc_q,      64'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        check("mid_no_done", 64'(saw_done), 64'd0);

        // Fresh span after the abort, two steps, Z-low mode
        load_basic();
        run_span(DADD_Z32_LO, 16'd2, 40, 1'b0, 1'b0);
        check("post_done_cyc", 64'(done_cyc), 64'd7);
        check("post_acc_q",    acc_q,         64'h0042_0032_0022_0012);
        check("post_daddmode", 64'(daddmode), 64'(DADD_Z32_LO));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
